// File: rtl/mtl_pkg.sv
// rtl/mtl_pkg.sv - shared MTL panel timing constants and sink state type
package mtl_pkg;

  typedef enum logic [1:0] {
    SEEK  = 2'd0,
    ALIGN = 2'd1,
    RUN   = 2'd2
  } mtl_state_e;

  // Default 800x480 MTL panel timing (H total 1056, V total 525)
  localparam int MTL_H_ACTIVE = 800;
  localparam int MTL_H_FRONT  = 210;
  localparam int MTL_H_SYNC   = 30;
  localparam int MTL_H_BACK   = 16;
  localparam int MTL_V_ACTIVE = 480;
  localparam int MTL_V_FRONT  = 22;
  localparam int MTL_V_SYNC   = 13;
  localparam int MTL_V_BACK   = 10;

endpackage

// File: rtl/mtl_counter.sv
// rtl/mtl_counter.sv - free-running h/v counters with active, sync and origin decode
module mtl_counter
  import mtl_pkg::*;
#(
  parameter int H_ACTIVE = MTL_H_ACTIVE,
  parameter int H_FRONT  = MTL_H_FRONT,
  parameter int H_SYNC   = MTL_H_SYNC,
  parameter int H_BACK   = MTL_H_BACK,
  parameter int V_ACTIVE = MTL_V_ACTIVE,
  parameter int V_FRONT  = MTL_V_FRONT,
  parameter int V_SYNC   = MTL_V_SYNC,
  parameter int V_BACK   = MTL_V_BACK
) (
  input  logic clk,
  input  logic reset_n,
  output logic active,
  output logic hs_n,
  output logic vs_n,
  output logic origin
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  // One extra count of headroom so the sync end compare stays representable
  localparam int HW = $clog2(H_TOTAL + 1);
  localparam int VW = $clog2(V_TOTAL + 1);

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_SYNC_S = HW'(H_ACTIVE + H_FRONT);
  localparam logic [HW-1:0] H_SYNC_E = HW'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_SYNC_S = VW'(V_ACTIVE + V_FRONT);
  localparam logic [VW-1:0] V_SYNC_E = VW'(V_ACTIVE + V_FRONT + V_SYNC);

  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [VW-1:0] vcnt_q, vcnt_d;

  // Advance hcnt every clock; at end of line wrap it and step vcnt
  always_comb begin
    hcnt_d = hcnt_q + 1'b1;
    vcnt_d = vcnt_q;
    if (hcnt_q == H_LAST) begin
      hcnt_d = '0;
      vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + 1'b1;
    end
  end

  // Counter registers restart at (0,0) on reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hcnt_q <= '0;
      vcnt_q <= '0;
    end else begin
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
    end
  end

  assign active = (hcnt_q < H_ACT) && (vcnt_q < V_ACT);
  assign hs_n   = !((hcnt_q >= H_SYNC_S) && (hcnt_q < H_SYNC_E));
  assign vs_n   = !((vcnt_q >= V_SYNC_S) && (vcnt_q < V_SYNC_E));
  assign origin = (hcnt_q == '0) && (vcnt_q == '0);

endmodule

// File: rtl/mtl_pixel_timing.sv
// rtl/mtl_pixel_timing.sv - MTL panel timing generator and resynchronising pixel-stream sink
module mtl_pixel_timing
  import mtl_pkg::*;
#(
  parameter int H_ACTIVE = MTL_H_ACTIVE,
  parameter int H_FRONT  = MTL_H_FRONT,
  parameter int H_SYNC   = MTL_H_SYNC,
  parameter int H_BACK   = MTL_H_BACK,
  parameter int V_ACTIVE = MTL_V_ACTIVE,
  parameter int V_FRONT  = MTL_V_FRONT,
  parameter int V_SYNC   = MTL_V_SYNC,
  parameter int V_BACK   = MTL_V_BACK
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [23:0] in_data,
  input  logic        in_sop,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        clear_status,
  output logic [7:0]  mtl_r,
  output logic [7:0]  mtl_g,
  output logic [7:0]  mtl_b,
  output logic        mtl_hs,
  output logic        mtl_vs,
  output logic        mtl_de,
  output logic        frame_start,
  output logic        underflow,
  output logic        sop_error,
  output logic        locked
);

  logic active, hs_n, vs_n, origin;

  mtl_counter #(
    .H_ACTIVE(H_ACTIVE), .H_FRONT(H_FRONT), .H_SYNC(H_SYNC), .H_BACK(H_BACK),
    .V_ACTIVE(V_ACTIVE), .V_FRONT(V_FRONT), .V_SYNC(V_SYNC), .V_BACK(V_BACK)
  ) u_counter (
    .clk    (clk),
    .reset_n(reset_n),
    .active (active),
    .hs_n   (hs_n),
    .vs_n   (vs_n),
    .origin (origin)
  );

  mtl_state_e  state_q, state_d;
  logic [23:0] rgb_q, rgb_d;
  logic        hs_q, hs_d, vs_q, vs_d, de_q, de_d, fs_q, fs_d;
  logic        uf_q, uf_d, se_q, se_d;
  logic        ready_c, set_uf, set_se;

  // Sink FSM: handshake, pixel selection and error events for this counter position
  always_comb begin
    state_d = state_q;
    ready_c = 1'b0;
    rgb_d   = '0;
    set_uf  = 1'b0;
    set_se  = 1'b0;
    case (state_q)
      SEEK: begin
        // Drain non-SOP words; an SOP is left pending upstream
        ready_c = !(in_valid && in_sop);
        if (in_valid && in_sop) state_d = ALIGN;
      end
      ALIGN: begin
        if (origin) begin
          ready_c = 1'b1;
          if (in_valid && in_sop) begin
            rgb_d   = in_data;
            state_d = RUN;
          end else begin
            // Held SOP vanished: hunt for the next one
            state_d = SEEK;
          end
        end
      end
      RUN: begin
        if (active) begin
          if (!in_valid) begin
            ready_c = 1'b1;
            set_uf  = 1'b1;
            state_d = SEEK;
          end else if (in_sop && !origin) begin
            // Early SOP is kept pending for the next frame start
            set_se  = 1'b1;
            state_d = ALIGN;
          end else if (!in_sop && origin) begin
            ready_c = 1'b1;
            set_se  = 1'b1;
            state_d = SEEK;
          end else begin
            ready_c = 1'b1;
            rgb_d   = in_data;
          end
        end
      end
      default: state_d = SEEK;
    endcase
  end

  // Output stage and sticky flags; a set event outranks clear_status
  always_comb begin
    hs_d = hs_n;
    vs_d = vs_n;
    de_d = active;
    fs_d = origin;
    uf_d = set_uf || (uf_q && !clear_status);
    se_d = set_se || (se_q && !clear_status);
  end

  // State, video output register and status flag flops
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= SEEK;
      rgb_q   <= '0;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      de_q    <= 1'b0;
      fs_q    <= 1'b0;
      uf_q    <= 1'b0;
      se_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rgb_q   <= rgb_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      de_q    <= de_d;
      fs_q    <= fs_d;
      uf_q    <= uf_d;
      se_q    <= se_d;
    end
  end

  // Gate with reset so ready drops immediately, not at the next edge
  assign in_ready    = reset_n && ready_c;
  assign mtl_r       = rgb_q[23:16];
  assign mtl_g       = rgb_q[15:8];
  assign mtl_b       = rgb_q[7:0];
  assign mtl_hs      = hs_q;
  assign mtl_vs      = vs_q;
  assign mtl_de      = de_q;
  assign frame_start = fs_q;
  assign underflow   = uf_q;
  assign sop_error   = se_q;
  assign locked      = (state_q == RUN);

endmodule

// File: doc/mtl_pixel_timing.md
# mtl_pixel_timing

Video timing generator and pixel-stream sink for the Terasic MTL 800x480 touch panel on the DE2-115 GPIO header. It consumes 24-bit RGB pixels from the upstream pixel-buffer DMA over a valid/ready stream with start-of-packet marking. It generates HS/VS/DE timing and drives registered RGB to the GPIO pin mapping in the top level. It resynchronises autonomously after stream underflow or misalignment and reports errors through sticky status flags.

## Interface
Parameters:
- H_ACTIVE, 800, visible pixels per line
- H_FRONT, 210, horizontal front porch (pixel clocks)
- H_SYNC, 30, HS pulse width
- H_BACK, 16, horizontal back porch (H total 1056)
- V_ACTIVE, 480, visible lines
- V_FRONT, 22, vertical front porch (lines)
- V_SYNC, 13, VS pulse width
- V_BACK, 10, vertical back porch (V total 525)

Ports:
- clk  in  1  pixel clock (33 MHz MTL clock domain)
- reset_n  in  1  asynchronous active-low reset
- in_data  in  24  pixel {R[7:0],G[7:0],B[7:0]}
- in_sop  in  1  marks first pixel of a frame
- in_valid  in  1  upstream word valid
- in_ready  out  1  sink ready; transfer when in_valid & in_ready
- clear_status  in  1  single-cycle pulse; clears sticky flags
- mtl_r / mtl_g / mtl_b  out  8 each  pixel colour
- mtl_hs / mtl_vs  out  1  sync, active-low
- mtl_de  out  1  data enable, high during active pixels
- frame_start  out  1  one-cycle pulse at x=0,y=0
- underflow  out  1  sticky: active pixel with no valid word in RUN
- sop_error  out  1  sticky: SOP misplaced or missing in RUN
- locked  out  1  high while state is RUN

## Operation
- Counters: hcnt 0..H_total-1, wraps to 0 and increments vcnt; vcnt 0..V_total-1, wraps to 0. Order within each line/frame: active, front, sync, back. Counters run free from reset, independent of the stream.
- active = hcnt<H_ACTIVE & vcnt<V_ACTIVE. hs_n low while hcnt in sync region. vs_n low for whole lines in the vertical sync region.
- State machine, reset state SEEK:
  - SEEK: in_ready=1 for non-SOP words, which are discarded. When in_valid & in_sop, in_ready=0 and the SOP word is held; go to ALIGN.
  - ALIGN: in_ready=0 until hcnt=0 & vcnt=0. That cycle asserts ready, consumes the SOP word as pixel (0,0), and goes to RUN.
  - RUN: in_ready = active. Each active cycle consumes one word.
    - Active & !in_valid: output black, set underflow, go to SEEK.
    - Valid word with in_sop at a position other than (0,0): do not consume, set sop_error, go to ALIGN.
    - At (0,0), valid word without in_sop: consume and discard, output black, set sop_error, go to SEEK.
- Outside RUN, or when not active, RGB output is 0.
- Sticky flags set on the event cycle. clear_status clears them. If a set event and clear_status occur in the same cycle, set wins.

## Timing
- Reset values: all RGB 0, mtl_hs=1, mtl_vs=1, mtl_de=0, frame_start=0, underflow=0, sop_error=0, locked=0, in_ready=0 (asynchronous, immediate), counters 0, state SEEK.
- in_ready is combinational from state/counters/in_valid/in_sop. No combinational path from in_data.
- All video outputs are registered, with one-cycle latency from the counter position: the pixel accepted at hcnt=k appears on mtl_r/g/b with mtl_de=1 at cycle k+1. HS, VS and DE are delayed by the same single stage, so they stay aligned.
- frame_start is registered and coincident with mtl_de for pixel (0,0).
- Minimum lock time after reset with a continuous stream: first SOP seen, then the next (0,0) — at most 1 frame (554400 clocks) plus SOP arrival time.
- Reset asserted mid-frame: outputs return to reset values asynchronously. After release, timing restarts at (0,0) and the state is SEEK.

## Structure
- Package mtl_pkg: state enum {SEEK, ALIGN, RUN}; default MTL timing constants, shared with the touch-controller and testbench.
- Sub-module mtl_counter: hcnt/vcnt generation plus active/hs/vs decode, parameterised by the timing values.
- Top: FSM, stream handshake, output register stage, status flags.

## Test plan
- Reset release, in_valid=0 throughout → hs low for 30 clocks every 1056, vs low for 13 lines every 525, de=0, locked=0, underflow=0.
- Continuous frames, SOP first → locked by the next (0,0). Pixel (x,y) with value {x[7:0],y[7:0],8'hA5} appears one cycle after its counter position, with de=1. Exactly 384000 transfers per frame.
- In RUN, drop in_valid for 1 cycle at (100,50) → that pixel is black, underflow=1, state SEEK. Relock at the next frame with the correct pixels.
- SOP injected at (10,0) → word not consumed, sop_error=1, state ALIGN. The word is consumed at the next (0,0) and locked=1.
- clear_status in the same cycle as a new underflow → underflow stays 1. clear_status alone → 0 on the next cycle.
- reset_n pulsed low mid-line in RUN → outputs reach reset values without a clock edge. After release, the frame restarts and the block relocks.
